// File: rtl/hilo_unit.sv
// HI/LO result register pair for a mult/div unit: it counts the issued ops that have not
// returned yet, then overwrites or accumulates each returning result and takes mthi/mtlo writes.
module hilo_unit #(
    parameter int W        = 32,
    parameter int PEND_MAX = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           op_start,
    input  logic           res_valid,
    output logic           res_ready,
    input  logic [2*W-1:0] res_data,
    input  logic [1:0]     res_mode,
    input  logic           mthi_we,
    input  logic           mtlo_we,
    input  logic [W-1:0]   mt_data,
    output logic [W-1:0]   hi_out,
    output logic [W-1:0]   lo_out,
    output logic [2*W-1:0] hilo_out,
    output logic           hilo_valid,
    output logic           err
);

    localparam logic [3:0] PEND_LIM = 4'(PEND_MAX);

    localparam logic [1:0] MODE_ADD = 2'b01;
    localparam logic [1:0] MODE_SUB = 2'b10;

    // Modes 00 and 11 both overwrite. Sums and differences wrap modulo 2^(2W).
    function automatic logic [2*W-1:0] hilo_combine(
        input logic [1:0]     mode,
        input logic [2*W-1:0] acc,
        input logic [2*W-1:0] res
    );
        logic [2*W-1:0] r;
        case (mode)
            MODE_ADD: r = acc + res;
            MODE_SUB: r = acc - res;
            default:  r = res;
        endcase
        return r;
    endfunction

    // The count saturates at the limit. An issue and a retire in the same cycle cancel out.
    function automatic logic [3:0] pend_update(
        input logic [3:0] cnt,
        input logic       inc,
        input logic       dec
    );
        logic [3:0] r;
        r = cnt;
        if (inc && !dec && cnt != PEND_LIM)
            r = cnt + 4'd1;
        else if (dec && !inc)
            r = cnt - 4'd1;
        return r;
    endfunction

    logic [W-1:0]   hi_p0;
    logic [W-1:0]   lo_p0;
    logic [3:0]     pend_cnt_p0;
    logic           err_p0;

    logic           accept;
    logic           overflow;
    logic           drop;
    logic [2*W-1:0] hilo_res;
    logic [W-1:0]   hi_nxt;
    logic [W-1:0]   lo_nxt;

    assign res_ready  = (pend_cnt_p0 != 4'd0);
    assign hilo_valid = (pend_cnt_p0 == 4'd0);
    assign accept     = res_valid && res_ready;
    assign overflow   = op_start && !accept && (pend_cnt_p0 == PEND_LIM);
    assign drop       = res_valid && (pend_cnt_p0 == 4'd0);

    always_comb begin
        hilo_res = {hi_p0, lo_p0};
        if (accept)
            hilo_res = hilo_combine(res_mode, {hi_p0, lo_p0}, res_data);
        hi_nxt = mthi_we ? mt_data : hilo_res[2*W-1:W];
        lo_nxt = mtlo_we ? mt_data : hilo_res[W-1:0];
    end

    // Stage p0: architectural state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_p0       <= '0;
            lo_p0       <= '0;
            pend_cnt_p0 <= 4'd0;
            err_p0      <= 1'b0;
        end else begin
            hi_p0       <= hi_nxt;
            lo_p0       <= lo_nxt;
            pend_cnt_p0 <= pend_update(pend_cnt_p0, op_start, accept);
            err_p0      <= err_p0 | overflow | drop;
        end
    end

    assign hi_out   = hi_p0;
    assign lo_out   = lo_p0;
    assign hilo_out = {hi_p0, lo_p0};
    assign err      = err_p0;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: accumulate, subtract, mt override, pending limit, drop, async reset.
module tb_hilo_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           op_start, res_valid, res_ready;
    logic [2*W-1:0] res_data;
    logic [1:0]     res_mode;
    logic           mthi_we, mtlo_we;
    logic [W-1:0]   mt_data;
    logic [W-1:0]   hi_out, lo_out;
    logic [2*W-1:0] hilo_out;
    logic           hilo_valid, err;

    int checks = 0;
    int errors = 0;

    hilo_unit #(.W(W), .PEND_MAX(3)) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_mode(res_mode),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .hi_out(hi_out), .lo_out(lo_out), .hilo_out(hilo_out),
        .hilo_valid(hilo_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Hold the inputs for one rising edge, then return them to idle 1 ns after that edge.
    task automatic cyc(input logic op, input logic rv, input logic [1:0] mode,
                       input logic [63:0] data, input logic whi, input logic wlo,
                       input logic [31:0] mtd);
        op_start  = op;
        res_valid = rv;
        res_mode  = mode;
        res_data  = data;
        mthi_we   = whi;
        mtlo_we   = wlo;
        mt_data   = mtd;
        @(posedge clk);
        #1;
        op_start  = 1'b0;
        res_valid = 1'b0;
        res_mode  = 2'b00;
        res_data  = '0;
        mthi_we   = 1'b0;
        mtlo_we   = 1'b0;
        mt_data   = '0;
    endtask

    initial begin
        reset = 1'b1;
        op_start = 0; res_valid = 0; res_mode = 0; res_data = 0;
        mthi_we = 0; mtlo_we = 0; mt_data = 0;
        #12;
        chk("rst_hilo", hilo_out, 64'h0);
        chk("rst_valid", hilo_valid, 1);
        chk("rst_ready", res_ready, 0);
        chk("rst_err", err, 0);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Two results accumulated, with the carry from LO propagated into HI
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        chk("acc_pend_valid", hilo_valid, 0);
        chk("acc_pend_ready", res_ready, 1);
        cyc(0, 1, 2'b01, 64'h00000001_FFFFFFFF, 0, 0, 32'h0);
        chk("acc1", hilo_out, 64'h00000001_FFFFFFFF);
        chk("acc1_valid", hilo_valid, 0);
        cyc(0, 1, 2'b01, 64'h00000001_FFFFFFFF, 0, 0, 32'h0);
        chk("acc2_hi", hi_out, 32'h00000003);
        chk("acc2_lo", lo_out, 32'hFFFFFFFE);
        chk("acc2_valid", hilo_valid, 1);
        chk("acc2_err", err, 0);

        // Subtracting from zero wraps to all ones
        cyc(0, 0, 2'b00, 64'h0, 1, 1, 32'h0);
        chk("mt_zero", hilo_out, 64'h0);
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        cyc(0, 1, 2'b10, 64'h1, 0, 0, 32'h0);
        chk("sub_wrap", hilo_out, 64'hFFFFFFFF_FFFFFFFF);
        chk("sub_err", err, 0);

        // A same-cycle mt write overrides only its own half of the result
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        cyc(0, 1, 2'b00, 64'h11111111_22222222, 1, 0, 32'hAAAAAAAA);
        chk("mthi_ovr_hi", hi_out, 32'hAAAAAAAA);
        chk("mthi_ovr_lo", lo_out, 32'h22222222);
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        cyc(0, 1, 2'b01, 64'h00000001_00000000, 0, 1, 32'h55555555);
        chk("mtlo_ovr", hilo_out, 64'hAAAAAAAB_55555555);
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        cyc(0, 1, 2'b11, 64'h00000002_00000000, 0, 0, 32'h0);
        chk("mode11", hilo_out, 64'h00000002_00000000);
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        cyc(0, 1, 2'b10, 64'h1, 0, 0, 32'h0);
        chk("sub_borrow", hilo_out, 64'h00000001_FFFFFFFF);
        chk("mid_err", err, 0);

        // The pending count saturates at PEND_MAX=3
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        chk("pend3_err", err, 0);
        cyc(1, 0, 2'b00, 64'h0, 0, 0, 32'h0);
        chk("ovf_err", err, 1);
        chk("ovf_valid", hilo_valid, 0);
        cyc(0, 1, 2'b00, 64'h7, 0, 0, 32'h0);
        cyc(0, 1, 2'b00, 64'h7, 0, 0, 32'h0);
        chk("ret2_valid", hilo_valid, 0);
        cyc(1, 1, 2'b00, 64'h9, 0, 0, 32'h0);
        chk("opret_valid", hilo_valid, 0);
        chk("opret_data", hilo_out, 64'h9);
        cyc(0, 1, 2'b00, 64'h7, 0, 0, 32'h0);
        chk("ret3_valid", hilo_valid, 1);
        chk("ret3_ready", res_ready, 0);

        // Asynchronous reset takes effect between clock edges, and inputs are ignored while it is held
        #2 reset = 1'b1;
        #1;
        chk("arst_hilo", hilo_out, 64'h0);
        chk("arst_err", err, 0);
        chk("arst_valid", hilo_valid, 1);
        op_start = 1'b1; mthi_we = 1'b1; mt_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("rst_ign_valid", hilo_valid, 1);
        chk("rst_ign_hi", hi_out, 32'h0);
        op_start = 1'b0; mthi_we = 1'b0; mt_data = 32'h0;
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // A beat with nothing pending is dropped, while an op_start in the same cycle still counts
        cyc(0, 0, 2'b00, 64'h0, 1, 1, 32'h0F0F0F0F);
        cyc(1, 1, 2'b00, 64'h123, 0, 0, 32'h0);
        chk("drop_hilo", hilo_out, 64'h0F0F0F0F_0F0F0F0F);
        chk("drop_err", err, 1);
        chk("drop_op_valid", hilo_valid, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst2_hilo", hilo_out, 64'h0);
        chk("arst2_err", err, 0);
        chk("arst2_ready", res_ready, 0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        cyc(0, 1, 2'b00, 64'h55, 0, 0, 32'h0);
        chk("post_rst_drop_hilo", hilo_out, 64'h0);
        chk("post_rst_drop_err", err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
